// File: rtl/vp_pkg.sv
// Shared types and helpers for the value-prediction validate queue.
package vp_pkg;

  localparam int unsigned VP_XLEN_LSB = 1;

  typedef struct packed {
    logic [31:VP_XLEN_LSB] pc;
    logic [31:VP_XLEN_LSB] value;
    logic                  conf;
  } vp_entry_t;

  function automatic int unsigned popcount_lanes(input logic [31:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      cnt += int'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/vp_mp_fifo.sv
// Multi-port circular buffer of vp_entry_t: up to P_NUM_PRED pushes and pops per cycle.
module vp_mp_fifo
  import vp_pkg::*;
#(
  parameter int unsigned P_NUM_PRED = 2,
  parameter int unsigned P_DEPTH    = 16,
  localparam int unsigned AW = $clog2(P_DEPTH),
  localparam int unsigned OW = AW + 1,
  localparam int unsigned CW = $clog2(P_NUM_PRED + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic [CW-1:0]                  push_cnt_i,
  input  vp_entry_t [P_NUM_PRED-1:0]     push_data_i,
  input  logic [CW-1:0]                  pop_cnt_i,
  output logic [OW-1:0]                  occupancy_o,
  output vp_entry_t [P_NUM_PRED-1:0]     peek_o
);

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [OW-1:0] occ_q, occ_d;
  vp_entry_t     mem_q [P_DEPTH];
  vp_entry_t     mem_d [P_DEPTH];

  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < P_NUM_PRED; i++) begin
      if (CW'(i) < push_cnt_i) begin
        mem_d[tail_q + AW'(i)] = push_data_i[i];
      end
    end
    tail_d = tail_q + AW'(push_cnt_i);
    head_d = head_q + AW'(pop_cnt_i);
    occ_d  = occ_q + OW'(push_cnt_i) - OW'(pop_cnt_i);
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < P_NUM_PRED; k++) begin
      peek_o[k] = mem_q[head_q + AW'(k)];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign occupancy_o = occ_q;

endmodule

// File: rtl/vp_validate_queue.sv
// Buffers predictions in program order and matches in-order execution results to train the predictor.
// Optional statistics counters are enabled with VP_VALQ_STATS_EN.
module vp_validate_queue
  import vp_pkg::*;
#(
  parameter int unsigned P_NUM_PRED  = 2,
  parameter int unsigned P_DEPTH     = 16,
  parameter int unsigned P_CNT_WIDTH = 16,
  localparam int unsigned AW = $clog2(P_DEPTH),
  localparam int unsigned OW = AW + 1,
  localparam int unsigned CW = $clog2(P_NUM_PRED + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [P_NUM_PRED-1:0][31:1]      pred_pc_i,
  input  logic [P_NUM_PRED-1:0][31:1]      pred_result_i,
  input  logic [P_NUM_PRED-1:0]            pred_conf_i,
  input  logic [P_NUM_PRED-1:0]            pred_valid_i,
  input  logic [P_NUM_PRED-1:0][31:1]      exe_pc_i,
  input  logic [P_NUM_PRED-1:0][31:1]      exe_result_i,
  input  logic [P_NUM_PRED-1:0]            exe_valid_i,
  input  logic                             flush_i,
  output logic [P_NUM_PRED-1:0][31:1]      fb_pc_o,
  output logic [P_NUM_PRED-1:0][31:1]      fb_actual_o,
  output logic [P_NUM_PRED-1:0]            fb_mispredict_o,
  output logic [P_NUM_PRED-1:0]            fb_conf_o,
  output logic [P_NUM_PRED-1:0]            fb_valid_o,
`ifdef VP_VALQ_STATS_EN
  output logic [P_CNT_WIDTH-1:0]           stat_correct_conf_o,
  output logic [P_CNT_WIDTH-1:0]           stat_wrong_conf_o,
  output logic [P_CNT_WIDTH-1:0]           stat_total_o,
`endif
  output logic [OW-1:0]                    occupancy_o,
  output logic [P_CNT_WIDTH-1:0]           drop_cnt_o,
  output logic [P_CNT_WIDTH-1:0]           stale_cnt_o
);

  function automatic logic [P_CNT_WIDTH-1:0] sat_add(input logic [P_CNT_WIDTH-1:0] cnt,
                                                     input logic [CW-1:0] inc);
    logic [P_CNT_WIDTH:0] sum;
    sum = {1'b0, cnt} + (P_CNT_WIDTH+1)'(inc);
    return sum[P_CNT_WIDTH] ? '1 : sum[P_CNT_WIDTH-1:0];
  endfunction

  logic [OW-1:0]                  occ;
  vp_entry_t [P_NUM_PRED-1:0]     peek;
  vp_entry_t [P_NUM_PRED-1:0]     push_data;
  logic [CW-1:0]                  n_push, push_cnt, pop_cnt;
  logic [OW-1:0]                  free_slots;
  logic                           blocked;

  logic [P_NUM_PRED-1:0][31:1]    fb_pc_q, fb_pc_d, fb_actual_q, fb_actual_d;
  logic [P_NUM_PRED-1:0]          fb_mis_q, fb_mis_d, fb_conf_q, fb_conf_d;
  logic [P_NUM_PRED-1:0]          fb_valid_q, fb_valid_d;
  logic [P_CNT_WIDTH-1:0]         drop_cnt_q, drop_cnt_d, stale_cnt_q, stale_cnt_d;

  vp_mp_fifo #(
    .P_NUM_PRED (P_NUM_PRED),
    .P_DEPTH    (P_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .push_cnt_i  (push_cnt),
    .push_data_i (push_data),
    .pop_cnt_i   (pop_cnt),
    .occupancy_o (occ),
    .peek_o      (peek)
  );

  // Free slots use pre-pop occupancy, so a full queue drops even when it pops this cycle.
  always_comb begin
    for (int unsigned i = 0; i < P_NUM_PRED; i++) begin
      push_data[i] = '{pc: pred_pc_i[i], value: pred_result_i[i], conf: pred_conf_i[i]};
    end
    n_push     = CW'(popcount_lanes(32'(pred_valid_i)));
    free_slots = OW'(P_DEPTH) - occ;
    push_cnt   = '0;
    drop_cnt_d = drop_cnt_q;
    if (!flush_i) begin
      if (free_slots >= OW'(n_push)) begin
        push_cnt = n_push;
      end else begin
        drop_cnt_d = sat_add(drop_cnt_q, n_push);
      end
    end
  end

  // The first failing lane blocks all later lanes; a pc mismatch still consumes its entry.
  always_comb begin
    blocked     = 1'b0;
    pop_cnt     = '0;
    stale_cnt_d = stale_cnt_q;
    fb_valid_d  = '0;
    fb_pc_d     = fb_pc_q;
    fb_actual_d = fb_actual_q;
    fb_mis_d    = fb_mis_q;
    fb_conf_d   = fb_conf_q;
    for (int unsigned k = 0; k < P_NUM_PRED; k++) begin
      if (!exe_valid_i[k] || blocked) begin
        blocked = 1'b1;
      end else if (occ > OW'(k)) begin
        pop_cnt = pop_cnt + CW'(1);
        if (peek[k].pc == exe_pc_i[k]) begin
          fb_valid_d[k]  = 1'b1;
          fb_pc_d[k]     = exe_pc_i[k];
          fb_actual_d[k] = exe_result_i[k];
          fb_mis_d[k]    = (peek[k].value != exe_result_i[k]);
          fb_conf_d[k]   = peek[k].conf;
        end else begin
          stale_cnt_d = sat_add(stale_cnt_q, CW'(1));
          blocked     = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fb_pc_q     <= '0;
      fb_actual_q <= '0;
      fb_mis_q    <= '0;
      fb_conf_q   <= '0;
      fb_valid_q  <= '0;
      drop_cnt_q  <= '0;
      stale_cnt_q <= '0;
    end else begin
      fb_pc_q     <= fb_pc_d;
      fb_actual_q <= fb_actual_d;
      fb_mis_q    <= fb_mis_d;
      fb_conf_q   <= fb_conf_d;
      fb_valid_q  <= fb_valid_d;
      drop_cnt_q  <= drop_cnt_d;
      stale_cnt_q <= stale_cnt_d;
    end
  end

`ifdef VP_VALQ_STATS_EN
  logic [P_CNT_WIDTH-1:0] st_ok_q, st_ok_d, st_bad_q, st_bad_d, st_tot_q, st_tot_d;
  logic [CW-1:0]          n_ok, n_bad, n_tot;

  always_comb begin
    n_ok  = '0;
    n_bad = '0;
    n_tot = '0;
    for (int unsigned k = 0; k < P_NUM_PRED; k++) begin
      if (fb_valid_d[k]) begin
        n_tot = n_tot + CW'(1);
        if (fb_conf_d[k] && !fb_mis_d[k]) n_ok  = n_ok + CW'(1);
        if (fb_conf_d[k] &&  fb_mis_d[k]) n_bad = n_bad + CW'(1);
      end
    end
    st_ok_d  = sat_add(st_ok_q, n_ok);
    st_bad_d = sat_add(st_bad_q, n_bad);
    st_tot_d = sat_add(st_tot_q, n_tot);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_ok_q  <= '0;
      st_bad_q <= '0;
      st_tot_q <= '0;
    end else begin
      st_ok_q  <= st_ok_d;
      st_bad_q <= st_bad_d;
      st_tot_q <= st_tot_d;
    end
  end

  assign stat_correct_conf_o = st_ok_q;
  assign stat_wrong_conf_o   = st_bad_q;
  assign stat_total_o        = st_tot_q;
`endif

  assign fb_pc_o         = fb_pc_q;
  assign fb_actual_o     = fb_actual_q;
  assign fb_mispredict_o = fb_mis_q;
  assign fb_conf_o       = fb_conf_q;
  assign fb_valid_o      = fb_valid_q;
  assign occupancy_o     = occ;
  assign drop_cnt_o      = drop_cnt_q;
  assign stale_cnt_o     = stale_cnt_q;

endmodule

// File: tb/tb_vp_validate_queue.sv
// Self-checking bench for vp_validate_queue: directed scenarios plus randomized traffic vs a queue model.
module tb_vp_validate_queue;

  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0][31:1] pred_pc, pred_res, exe_pc, exe_res;
  logic [1:0]       pred_conf, pred_valid, exe_valid;
  logic             flush;

  logic [1:0][31:1] fb_pc, fb_actual;
  logic [1:0]       fb_mis, fb_conf, fb_valid;
  logic [4:0]       occupancy;
  logic [15:0]      drop_cnt, stale_cnt;

  vp_validate_queue #(
    .P_NUM_PRED  (2),
    .P_DEPTH     (DEPTH),
    .P_CNT_WIDTH (16)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .pred_pc_i       (pred_pc),
    .pred_result_i   (pred_res),
    .pred_conf_i     (pred_conf),
    .pred_valid_i    (pred_valid),
    .exe_pc_i        (exe_pc),
    .exe_result_i    (exe_res),
    .exe_valid_i     (exe_valid),
    .flush_i         (flush),
    .fb_pc_o         (fb_pc),
    .fb_actual_o     (fb_actual),
    .fb_mispredict_o (fb_mis),
    .fb_conf_o       (fb_conf),
    .fb_valid_o      (fb_valid),
    .occupancy_o     (occupancy),
    .drop_cnt_o      (drop_cnt),
    .stale_cnt_o     (stale_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:1] pc;
    logic [31:1] val;
    logic        conf;
  } ent_t;

  ent_t        mq[$];
  logic [1:0][31:1] m_pc, m_act;
  logic [1:0]  m_mis, m_conf, m_fbv;
  int          m_drop, m_stale;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: queue semantics taken straight from the behavioural rules.
  task automatic model_cycle();
    int  occ, npop, n;
    bit  stop;
    if (rst) begin
      mq.delete();
      m_pc = '0; m_act = '0; m_mis = '0; m_conf = '0; m_fbv = '0;
      m_drop = 0; m_stale = 0;
      return;
    end
    occ  = mq.size();
    npop = 0;
    stop = 0;
    m_fbv = '0;
    for (int k = 0; k < 2; k++) begin
      if (!exe_valid[k] || stop || occ <= k) begin
        stop = 1;
      end else begin
        npop++;
        if (mq[k].pc == exe_pc[k]) begin
          m_fbv[k]  = 1'b1;
          m_pc[k]   = exe_pc[k];
          m_act[k]  = exe_res[k];
          m_mis[k]  = (mq[k].val != exe_res[k]);
          m_conf[k] = mq[k].conf;
        end else begin
          if (m_stale < 65535) m_stale++;
          stop = 1;
        end
      end
    end
    n = int'(pred_valid[0]) + int'(pred_valid[1]);
    for (int i = 0; i < npop; i++) void'(mq.pop_front());
    if (!flush) begin
      if (DEPTH - occ >= n) begin
        for (int k = 0; k < n; k++) mq.push_back('{pred_pc[k], pred_res[k], pred_conf[k]});
      end else begin
        m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
      end
    end else begin
      mq.delete();
    end
  endtask

  task automatic compare_all();
    check("fb_valid", 64'(fb_valid), 64'(m_fbv));
    check("occupancy", 64'(occupancy), 64'(mq.size()));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check("stale_cnt", 64'(stale_cnt), 64'(m_stale));
    for (int k = 0; k < 2; k++) begin
      check($sformatf("fb_pc%0d", k), 64'(fb_pc[k]), 64'(m_pc[k]));
      check($sformatf("fb_actual%0d", k), 64'(fb_actual[k]), 64'(m_act[k]));
      check($sformatf("fb_mis%0d", k), 64'(fb_mis[k]), 64'(m_mis[k]));
      check($sformatf("fb_conf%0d", k), 64'(fb_conf[k]), 64'(m_conf[k]));
    end
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0;
    pred_valid = '0; exe_valid = '0;
    pred_pc = '0; pred_res = '0; pred_conf = '0;
    exe_pc = '0; exe_res = '0;
  endtask

  task automatic push1(input int lane, input logic [31:1] pc, input logic [31:1] v, input logic c);
    pred_valid[lane] = 1'b1;
    pred_pc[lane] = pc; pred_res[lane] = v; pred_conf[lane] = c;
  endtask

  task automatic exe1(input int lane, input logic [31:1] pc, input logic [31:1] r);
    exe_valid[lane] = 1'b1;
    exe_pc[lane] = pc; exe_res[lane] = r;
  endtask

  task automatic rand_cycle(input int push_pct, input int exe_pct, input int flush_pm,
                            input int rst_pm, inout int pc_ctr);
    int np, ne;
    idle();
    np = ($urandom_range(0, 99) < push_pct) ? $urandom_range(1, 2) : 0;
    for (int k = 0; k < np; k++) begin
      push1(k, 31'(pc_ctr), 31'($urandom), 1'($urandom));
      pc_ctr += 4;
    end
    ne = ($urandom_range(0, 99) < exe_pct) ? $urandom_range(1, 2) : 0;
    for (int k = 0; k < ne; k++) begin
      if (k < mq.size() && $urandom_range(0, 9) != 0)
        exe1(k, mq[k].pc, $urandom_range(0, 1) ? mq[k].val : 31'($urandom));
      else
        exe1(k, 31'($urandom), 31'($urandom));
    end
    flush = ($urandom_range(0, 999) < flush_pm);
    rst   = ($urandom_range(0, 999) < rst_pm);
    step();
  endtask

  initial begin
    int pc_ctr;
    idle();
    rst = 1'b1;
    step();
    step();
    idle();

    // Single-lane push then matching execute.
    push1(0, 31'h100, 31'h5, 1'b1);
    step();
    idle();
    exe1(0, 31'h100, 31'h5);
    step();
    check("t1_fbv", 64'(fb_valid), 64'h1);
    check("t1_mis", 64'(fb_mis[0]), 64'h0);
    check("t1_conf", 64'(fb_conf[0]), 64'h1);
    check("t1_occ", 64'(occupancy), 64'h0);

    // Two-lane push then two-lane execute, lane 1 mispredicted.
    idle();
    push1(0, 31'h100, 31'h5, 1'b0);
    push1(1, 31'h104, 31'h9, 1'b1);
    step();
    idle();
    exe1(0, 31'h100, 31'h5);
    exe1(1, 31'h104, 31'h7);
    step();
    check("t2_fbv", 64'(fb_valid), 64'h3);
    check("t2_mis", 64'(fb_mis), 64'h2);

    // Fill to full, overflow drops, pop in the same cycle still drops.
    for (int i = 0; i < 8; i++) begin
      idle();
      push1(0, 31'(32'h300 + 8 * i), 31'(i), 1'b1);
      push1(1, 31'(32'h304 + 8 * i), 31'(i + 100), 1'b0);
      step();
    end
    check("t3_full", 64'(occupancy), 64'd16);
    idle();
    push1(0, 31'h900, 31'h1, 1'b1);
    push1(1, 31'h904, 31'h2, 1'b1);
    step();
    check("t3_drop", 64'(drop_cnt), 64'd2);
    check("t3_occ", 64'(occupancy), 64'd16);
    exe1(0, 31'h300, 31'h0);
    step();
    check("t3_drop_pop", 64'(drop_cnt), 64'd4);
    check("t3_occ_pop", 64'(occupancy), 64'd15);
    check("t3_fbv", 64'(fb_valid), 64'h1);

    // Flush with same-cycle push and matching execute.
    idle();
    flush = 1'b1;
    push1(0, 31'hA00, 31'h1, 1'b1);
    push1(1, 31'hA04, 31'h2, 1'b1);
    exe1(0, 31'h304, 31'd100);
    step();
    check("t5_fbv", 64'(fb_valid), 64'h1);
    check("t5_occ", 64'(occupancy), 64'h0);
    check("t5_drop", 64'(drop_cnt), 64'd4);

    // Head pc mismatch pops one entry and suppresses lane 1.
    idle();
    push1(0, 31'h200, 31'h1, 1'b1);
    push1(1, 31'h208, 31'h2, 1'b1);
    step();
    idle();
    exe1(0, 31'h204, 31'h1);
    exe1(1, 31'h208, 31'h2);
    step();
    check("t4_fbv", 64'(fb_valid), 64'h0);
    check("t4_stale", 64'(stale_cnt), 64'd1);
    check("t4_occ", 64'(occupancy), 64'd1);
    idle();
    flush = 1'b1;
    step();

    // Steady 1-in/1-out stream across pointer wraps.
    idle();
    push1(0, 31'h400, 31'd0, 1'b1);
    step();
    for (int i = 0; i < 40; i++) begin
      idle();
      push1(0, 31'(32'h404 + 4 * i), 31'(3 * (i + 1)), 1'b1);
      exe1(0, 31'(32'h400 + 4 * i), 31'(3 * i));
      step();
      check("wrap_fbv", 64'(fb_valid), 64'h1);
      check("wrap_occ", 64'(occupancy), 64'h1);
    end

    // Randomized traffic: fill-heavy, balanced, drain-heavy.
    pc_ctr = 32'h1000;
    for (int i = 0; i < 600; i++) rand_cycle(90, 20, 5, 2, pc_ctr);
    for (int i = 0; i < 800; i++) rand_cycle(60, 60, 10, 2, pc_ctr);
    for (int i = 0; i < 600; i++) rand_cycle(20, 90, 5, 2, pc_ctr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
